spi_xfer_sequencer: RTL
=======================

SPI_XFER_SEQUENCER -- requirements
Module: spi_xfer_sequencer

Interface
REQ-001 SHALL have parameter LEN_W, default 4: width of len_in; one transfer carries 1..2^LEN_W bytes.
REQ-002 SHALL have port clk_in, input, 1: single clock; all logic on rising edge.
REQ-003 SHALL have port reset_n_in, input, 1: asynchronous, active-low reset.
REQ-004 SHALL have port start_in, input, 1: transfer request; sampled only in IDLE.
REQ-005 SHALL have port len_in, input, LEN_W: byte count minus 1; captured with start_in.
REQ-006 SHALL have port div_in, input, 4: SPI divider value; captured with start_in.
REQ-007 SHALL have port abort_in, input, 1: level; ends the transfer at the next byte boundary.
REQ-008 SHALL have port tx_data_in, input, 8: next byte to send.
REQ-009 SHALL have port tx_valid_in, input, 1: tx_data_in valid.
REQ-010 SHALL have port tx_ready_out, output, 1: byte accepted when tx_valid_in && tx_ready_out.
REQ-011 SHALL have port busy_out, output, 1: high in every state except IDLE.
REQ-012 SHALL have port done_out, output, 1: one-cycle pulse at transfer end.
REQ-013 SHALL have port aborted_out, output, 1: registered; set with done_out if abort ended the transfer, cleared on next accepted start_in.
REQ-014 SHALL have port periph_addr_out, output, 3: peripheral register address.
REQ-015 SHALL have port periph_addr_valid_out, output, 1: access strobe; one cycle per access.
REQ-016 SHALL have port periph_write_en_out, output, 1: 1 = write, 0 = read.
REQ-017 SHALL have port periph_data_out, output, 8: write data.
REQ-018 SHALL have port periph_data_in, input, 8: read data.
REQ-019 SHALL have port periph_data_valid_in, input, 1: read data valid, one cycle after the read strobe.

Function
REQ-020 SHALL use the peripheral map 4 = divider, 5 = CS (bit0), 6 = status (bit0 busy), 7 = data.
REQ-021 SHALL implement states IDLE, SET_DIV, CS_LOW, GET_BYTE, WR_DATA, POLL, POLL_WAIT, CS_HIGH, DONE.
REQ-022 SHALL move IDLE->SET_DIV on start_in, capturing len_in into remaining-count register and div_in.
REQ-023 SHALL, in SET_DIV, issue one write of {4'h0,div} to address 4, then go to CS_LOW.
REQ-024 SHALL, in CS_LOW, issue one write of 8'h00 to address 5, then go to GET_BYTE.
REQ-025 SHALL, in GET_BYTE, drive tx_ready_out=1 and wait indefinitely; on handshake, latch the byte and go to WR_DATA.
REQ-026 SHALL keep tx_ready_out=0 in every state except GET_BYTE.
REQ-027 SHALL, in WR_DATA, issue one write of the latched byte to address 7, then go to POLL.
REQ-028 SHALL, in POLL, issue one read of address 6, then go to POLL_WAIT; strobes SHALL never occur in consecutive cycles during polling.
REQ-029 SHALL, in POLL_WAIT, act on periph_data_valid_in: bit0=1 -> POLL; bit0=0 -> byte complete.
REQ-030 SHALL, on byte complete, go to CS_HIGH if remaining count = 0 or abort_in = 1; otherwise decrement remaining count and go to GET_BYTE.
REQ-031 SHALL, in CS_HIGH, issue one write of 8'h01 to address 5, then go to DONE.
REQ-032 SHALL, in DONE, pulse done_out for one cycle, update aborted_out, then return to IDLE.
REQ-033 SHALL treat len_in = all-ones as 2^LEN_W bytes; the count register SHALL NOT wrap.
REQ-034 SHALL ignore abort_in asserted in IDLE, SET_DIV or CS_LOW until the first byte completes; at least one byte is always sent.
REQ-035 SHALL ignore start_in when not in IDLE; a start_in coincident with DONE is dropped.
REQ-036 SHALL drive all bus outputs to 0 in cycles with no access.

Reset
REQ-037 SHALL, on reset_n_in low, asynchronously enter IDLE and clear all outputs and internal registers to 0.
REQ-038 SHALL, on reset mid-transfer, leave CS deassertion to the peripheral's own reset; no bus access is issued during reset.

Verification
REQ-039 SHALL cover: len=0, div=2, byte 8'hA5 -> writes (4,02),(5,00),(7,A5); status polled until 0; then (5,01); one done_out pulse; aborted_out=0.
REQ-040 SHALL cover: len=2, bytes 11/22/33, tx_valid_in stalled 5 cycles before byte 2 -> three data writes in order; CS written low once and high once.
REQ-041 SHALL cover: len=15 -> exactly 16 data writes; count does not wrap.
REQ-042 SHALL cover: abort_in asserted during byte 2 of len=5 -> CS high after byte 2 completes; aborted_out=1.
REQ-043 SHALL cover: reset_n_in low during POLL_WAIT -> immediate IDLE, busy_out=0, no further strobes; a subsequent start_in runs normally.
REQ-044 SHALL cover: start_in held while busy_out=1 -> no second transfer after done_out.

Source files
------------

// File: rtl/spi_xfer_sequencer.sv
// SPI transfer sequencer: drives a register-mapped SPI peripheral through
// divider setup, chip select, per-byte data write and status polling.
module spi_xfer_sequencer #(
    parameter int LEN_W = 4
) (
    input  logic             clk_in,
    input  logic             reset_n_in,
    input  logic             start_in,
    input  logic [LEN_W-1:0] len_in,
    input  logic [3:0]       div_in,
    input  logic             abort_in,
    input  logic [7:0]       tx_data_in,
    input  logic             tx_valid_in,
    output logic             tx_ready_out,
    output logic             busy_out,
    output logic             done_out,
    output logic             aborted_out,
    output logic [2:0]       periph_addr_out,
    output logic             periph_addr_valid_out,
    output logic             periph_write_en_out,
    output logic [7:0]       periph_data_out,
    input  logic [7:0]       periph_data_in,
    input  logic             periph_data_valid_in
);

    typedef enum logic [3:0] {
        S_IDLE,
        S_SET_DIV,
        S_CS_LOW,
        S_GET_BYTE,
        S_WR_DATA,
        S_POLL,
        S_POLL_WAIT,
        S_CS_HIGH,
        S_DONE
    } state_t;

    localparam logic [2:0] A_DIV  = 3'd4;
    localparam logic [2:0] A_CS   = 3'd5;
    localparam logic [2:0] A_STAT = 3'd6;
    localparam logic [2:0] A_DATA = 3'd7;

    state_t           r_state;
    logic [LEN_W-1:0] r_cnt;
    logic             r_abt;
    logic             r_busy;
    logic             r_done;
    logic             r_aborted;
    logic             r_tx_ready;
    logic             r_avalid;
    logic             r_we;
    logic [2:0]       r_addr;
    logic [7:0]       r_pdata;

    logic w_stat_busy;
    logic w_last;
    logic w_unused;

    assign w_stat_busy = periph_data_in[0];
    assign w_last      = (r_cnt == '0) || abort_in;
    assign w_unused    = ^periph_data_in[7:1];

    // Bus outputs are registered on the edge entering the access state,
    // so each strobe lines up with the one cycle spent in that state.
    always_ff @(posedge clk_in or negedge reset_n_in) begin
        if (!reset_n_in) begin
            r_state    <= S_IDLE;
            r_cnt      <= '0;
            r_abt      <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_aborted  <= 1'b0;
            r_tx_ready <= 1'b0;
            r_avalid   <= 1'b0;
            r_we       <= 1'b0;
            r_addr     <= '0;
            r_pdata    <= '0;
        end else begin
            r_avalid   <= 1'b0;
            r_we       <= 1'b0;
            r_addr     <= '0;
            r_pdata    <= '0;
            r_done     <= 1'b0;
            r_tx_ready <= 1'b0;
            unique case (r_state)
                S_IDLE: begin
                    if (start_in) begin
                        r_state   <= S_SET_DIV;
                        r_busy    <= 1'b1;
                        r_cnt     <= len_in;
                        r_abt     <= 1'b0;
                        r_aborted <= 1'b0;
                        r_avalid  <= 1'b1;
                        r_we      <= 1'b1;
                        r_addr    <= A_DIV;
                        r_pdata   <= {4'h0, div_in};
                    end
                end
                S_SET_DIV: begin
                    r_state  <= S_CS_LOW;
                    r_avalid <= 1'b1;
                    r_we     <= 1'b1;
                    r_addr   <= A_CS;
                    r_pdata  <= 8'h00;
                end
                S_CS_LOW: begin
                    r_state    <= S_GET_BYTE;
                    r_tx_ready <= 1'b1;
                end
                S_GET_BYTE: begin
                    if (tx_valid_in) begin
                        r_state  <= S_WR_DATA;
                        r_avalid <= 1'b1;
                        r_we     <= 1'b1;
                        r_addr   <= A_DATA;
                        r_pdata  <= tx_data_in;
                    end else begin
                        r_tx_ready <= 1'b1;
                    end
                end
                S_WR_DATA: begin
                    r_state  <= S_POLL;
                    r_avalid <= 1'b1;
                    r_addr   <= A_STAT;
                end
                S_POLL: begin
                    r_state <= S_POLL_WAIT;
                end
                S_POLL_WAIT: begin
                    if (periph_data_valid_in) begin
                        if (w_stat_busy) begin
                            r_state  <= S_POLL;
                            r_avalid <= 1'b1;
                            r_addr   <= A_STAT;
                        end else if (w_last) begin
                            r_state  <= S_CS_HIGH;
                            r_abt    <= abort_in && (r_cnt != '0);
                            r_avalid <= 1'b1;
                            r_we     <= 1'b1;
                            r_addr   <= A_CS;
                            r_pdata  <= 8'h01;
                        end else begin
                            r_state    <= S_GET_BYTE;
                            r_cnt      <= r_cnt - 1'b1;
                            r_tx_ready <= 1'b1;
                        end
                    end
                end
                S_CS_HIGH: begin
                    r_state   <= S_DONE;
                    r_done    <= 1'b1;
                    r_aborted <= r_abt;
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign tx_ready_out          = r_tx_ready;
    assign busy_out              = r_busy;
    assign done_out              = r_done;
    assign aborted_out           = r_aborted;
    assign periph_addr_out       = r_addr;
    assign periph_addr_valid_out = r_avalid;
    assign periph_write_en_out   = r_we;
    assign periph_data_out       = r_pdata;

endmodule
